vga_scan_controller: RTL and testbench
======================================

# vga_scan_controller

- Generates VGA raster timing (640x480 default) from the system clock.
- Drives the `row`/`col` coordinates that the sprite/menu modules decode combinationally, and samples their returned 3-bit `rgb`.
- Registers that pixel, blanked outside the visible area, onto the VGA pins together with aligned hsync/vsync.
- Sits between the menu/graphics modules and the board's VGA connector; it is the requesting end of the row/col → rgb interface.

## Interface

Parameters (name, default, meaning):
- `H_VISIBLE`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_VISIBLE`, 480, visible lines
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `CLK_DIV`, 2, system clocks per pixel (≥1)
- `SYNC_ACTIVE_LOW`, 1, 1 means sync pulses drive 0

Ports (name, direction, width, meaning):
- `clk`, in, 1, system clock
- `reset`, in, 1, synchronous, active-high reset
- `rgb`, in, 3, pixel for current `row`/`col`, combinational from graphics modules
- `row`, out, 10, current vertical coordinate (line counter)
- `col`, out, 10, current horizontal coordinate (pixel counter)
- `vga_rgb`, out, 3, registered pixel to DAC/pins
- `vga_hsync`, out, 1, registered horizontal sync
- `vga_vsync`, out, 1, registered vertical sync
- `frame_start`, out, 1, one-`clk` pulse at start of each frame

## Operation

- Derived constants:
  - H_TOTAL = sum of the four H parameters (800 at defaults).
  - V_TOTAL = sum of the four V parameters (525 at defaults).
  - Both must be ≤ 1024.
- Pixel enable:
  - `div_cnt` counts 0..CLK_DIV-1, wrapping.
  - `pix_en` = (`div_cnt` == CLK_DIV-1). With CLK_DIV=1, `pix_en` is constant 1.
- Counters, updated only on `pix_en`:
  - `col` increments. At H_TOTAL-1 it wraps to 0 and `row` increments.
  - `row` wraps from V_TOTAL-1 to 0 at the same edge that `col` wraps.
  - `row` and `col` are the counter registers themselves and continue counting through blanking.
- Output stage, updated only on `pix_en`, using the pre-increment `row`/`col` values:
  - `vga_rgb` ← visible ? `rgb` : 3'b000, where visible = `col` < H_VISIBLE and `row` < V_VISIBLE.
  - hsync is active while `col` ∈ [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC), i.e. [656,752) at defaults.
  - vsync is active while `row` ∈ [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC), i.e. [490,492) at defaults.
  - Output level is active = !SYNC_ACTIVE_LOW.
- `frame_start` goes high for exactly one `clk` in the cycle after the `pix_en` that wraps (`col`, `row`) from (H_TOTAL-1, V_TOTAL-1) to (0,0).
- Reset values:
  - `div_cnt`=0, `row`=0, `col`=0.
  - `vga_rgb`=0.
  - Syncs at inactive level (1 at defaults).
  - `frame_start`=0.
- Reset takes priority over `pix_en`. Reset mid-line or mid-frame returns every register to its reset value on the next edge.
- No `frame_start` pulse is generated by reset itself. The first pulse follows the first full frame.

## Timing

- `row`/`col` change only on the `clk` edge where `pix_en`=1. They are stable for CLK_DIV clocks, giving the graphics path CLK_DIV-1 full cycles of combinational settling plus the sampling cycle.
- Output latency:
  - `vga_rgb`, `vga_hsync` and `vga_vsync` correspond to the coordinate of the previous pixel period, one pixel period of latency.
  - The three outputs are mutually aligned.
- First `pix_en` after reset deassertion occurs on the CLK_DIV-th clock edge.
- Line period = H_TOTAL × CLK_DIV clocks (1600). Frame period = H_TOTAL × V_TOTAL × CLK_DIV clocks (840000).
- `rgb` is sampled only on `pix_en` edges. Its value in other cycles is ignored.

## Structure

- Shared package `vga_timing_pkg` holds:
  - the default 640x480 timing constants;
  - derived H_TOTAL and V_TOTAL;
  - the 3-bit colour constants (black = 3'b000).
- The menu modules also import `vga_timing_pkg` for screen bounds.
- One sub-module, `pixel_clock_enable`:
  - contains the `CLK_DIV` counter;
  - has ports `clk`, `reset`, `pix_en`.
- The counters and output registers live in the top module.

## Test plan

- **Reset, then free-run:**
  - Required: first `pix_en` at clock 2.
  - Required: `col` reaches 799, then 0, with `row` going 0→1 after 800 `pix_en` (1600 clk).
- **hsync shape:**
  - Required: `vga_hsync` goes low on the edge sampling `col`=656.
  - Required: it stays low for exactly 96 pixel periods (192 clk) and returns high on the edge sampling `col`=752.
- **vsync shape:**
  - Required: `vga_vsync` goes low on the edge sampling (`col`=0, `row`=490).
  - Required: it stays low for exactly 1600 pixel periods.
- **Blanking and passthrough:**
  - Stimulus: `rgb` driven with `col[2:0]`.
  - Required: in the visible area, `vga_rgb` equals the previous pixel's `col[2:0]`.
  - Stimulus: `rgb` forced to 3'b111.
  - Required: `vga_rgb` is 3'b000 for `col` 640..799 and for `row` 480..524.
- **frame_start cadence:**
  - Required: exactly one 1-clk pulse every 840000 clk, none during the first frame after reset.
- **Mid-frame reset:**
  - Stimulus: `reset` asserted for 1 clk at (`col`=300, `row`=200).
  - Required: next edge gives `row`=`col`=0, `vga_rgb`=0, syncs high, `frame_start`=0.
  - Required: counting restarts with the first `pix_en` 2 clk after deassertion.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared raster constants for the VGA path. The scan controller takes its
// parameter defaults from here. The menu and sprite modules import it for
// screen bounds and colour values.
// No ports (package).
package vga_timing_pkg;

    // 640x480 at 60 Hz timing, in pixels and lines.
    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    // 3-bit colour constants, ordered {r, g, b}.
    localparam logic [2:0] RGB_BLACK = 3'b000;
    localparam logic [2:0] RGB_BLUE  = 3'b001;
    localparam logic [2:0] RGB_GREEN = 3'b010;
    localparam logic [2:0] RGB_RED   = 3'b100;
    localparam logic [2:0] RGB_WHITE = 3'b111;

endpackage

// File: rtl/pixel_clock_enable.sv
// pixel_clock_enable
// Produces a one-clk pixel strobe every CLK_DIV system clocks.
// Ports:
//   clk    - system clock
//   reset  - synchronous, active-high reset
//   pix_en - high on the last clock of every CLK_DIV-clock pixel period
module pixel_clock_enable #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    output logic pix_en
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;

    // With CLK_DIV=1, DIV_LAST is 0, so div_cnt never leaves 0 and the
    // strobe is constantly high.
    assign pix_en = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset || pix_en) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_scan_controller.sv
// vga_scan_controller
// Generates VGA raster timing. It presents the row/col coordinate to the
// graphics modules and registers the rgb value they return, with that pixel
// blanked outside the visible area, onto the VGA pins. hsync and vsync are
// registered alongside it.
// Ports:
//   clk         - system clock
//   reset       - synchronous, active-high reset
//   rgb         - pixel for the current row/col, combinational from graphics
//   row, col    - current line / pixel counters (run through blanking)
//   vga_rgb     - registered, blanked pixel to the DAC pins
//   vga_hsync   - registered horizontal sync, aligned with vga_rgb
//   vga_vsync   - registered vertical sync, aligned with vga_rgb
//   frame_start - one-clk pulse after the counters wrap to (0,0)
module vga_scan_controller
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE       = H_VISIBLE_DEF,
    parameter int H_FRONT         = H_FRONT_DEF,
    parameter int H_SYNC          = H_SYNC_DEF,
    parameter int H_BACK          = H_BACK_DEF,
    parameter int V_VISIBLE       = V_VISIBLE_DEF,
    parameter int V_FRONT         = V_FRONT_DEF,
    parameter int V_SYNC          = V_SYNC_DEF,
    parameter int V_BACK          = V_BACK_DEF,
    parameter int CLK_DIV         = 2,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] rgb,
    output logic [9:0] row,
    output logic [9:0] col,
    output logic [2:0] vga_rgb,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic       frame_start
);

    // Totals may reach 1024. Comparisons therefore use 11 bits, so that
    // H_VISIBLE+H_FRONT+H_SYNC = 1024 (H_BACK = 0) still fits.
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] HS_BEGIN = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_BEGIN = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam logic SYNC_ON  = (SYNC_ACTIVE_LOW == 0);
    localparam logic SYNC_OFF = ~SYNC_ON;

    logic       pix_en;
    logic       col_wrap;
    logic       row_wrap;
    logic       visible;
    logic       hs_on;
    logic       vs_on;
    logic [2:0] rgb_p1;
    logic       hsync_p1;
    logic       vsync_p1;
    logic       frame_start_p1;

    pixel_clock_enable #(
        .CLK_DIV(CLK_DIV)
    ) u_pixel_clock_enable (
        .clk   (clk),
        .reset (reset),
        .pix_en(pix_en)
    );

    always_comb begin
        col_wrap = ({1'b0, col} == H_LAST);
        row_wrap = ({1'b0, row} == V_LAST);
        visible  = ({1'b0, col} < H_VIS) && ({1'b0, row} < V_VIS);
        hs_on    = ({1'b0, col} >= HS_BEGIN) && ({1'b0, col} < HS_END);
        vs_on    = ({1'b0, row} >= VS_BEGIN) && ({1'b0, row} < VS_END);
    end

    // ---- stage p0: raster counters (these are the row/col outputs) ----
    always_ff @(posedge clk) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (pix_en) begin
            if (col_wrap) begin
                col <= '0;
                row <= row_wrap ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // ---- stage p1: pin registers, one pixel period behind row/col ----
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_p1         <= RGB_BLACK;
            hsync_p1       <= SYNC_OFF;
            vsync_p1       <= SYNC_OFF;
            frame_start_p1 <= 1'b0;
        end else begin
            // Counters never reach (H_LAST, V_LAST) during reset, so reset
            // cannot cause a pulse; the first pulse follows a full frame.
            frame_start_p1 <= pix_en && col_wrap && row_wrap;
            if (pix_en) begin
                rgb_p1   <= visible ? rgb : RGB_BLACK;
                hsync_p1 <= hs_on ? SYNC_ON : SYNC_OFF;
                vsync_p1 <= vs_on ? SYNC_ON : SYNC_OFF;
            end
        end
    end

    assign vga_rgb     = rgb_p1;
    assign vga_hsync   = hsync_p1;
    assign vga_vsync   = vsync_p1;
    assign frame_start = frame_start_p1;

endmodule

// File: tb/tb_vga_scan_controller.sv
// tb_vga_scan_controller
// Randomised bench for vga_scan_controller using a reduced raster, so that
// several whole frames fit in a short run. The reference model counts clock
// edges since reset. From that count it derives the pixel index, the
// coordinate, and what the pins must show, using plain arithmetic.
module tb_vga_scan_controller;

    localparam int HV = 20;
    localparam int HF = 3;
    localparam int HS = 5;
    localparam int HB = 4;
    localparam int VV = 12;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int D  = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME     = HT * VT;
    localparam int FRAME_CLK = FRAME * D;

    logic       clk;
    logic       reset;
    logic [2:0] rgb;
    logic [9:0] row;
    logic [9:0] col;
    logic [2:0] vga_rgb;
    logic       vga_hsync;
    logic       vga_vsync;
    logic       frame_start;

    int         n_vec;
    int         n_miss;
    int         k;       // clock edges since the last reset edge
    int         p;       // pixel strobes since the last reset edge
    logic [2:0] samp;    // rgb value seen at the latest pixel strobe

    vga_scan_controller #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .CLK_DIV(D), .SYNC_ACTIVE_LOW(1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rgb        (rgb),
        .row        (row),
        .col        (col),
        .vga_rgb    (vga_rgb),
        .vga_hsync  (vga_hsync),
        .vga_vsync  (vga_vsync),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d after reset)", tag, got, exp, k);
        end
    endtask

    // Expected pin state after k edges. Pixel strobes fall on every D-th
    // edge. The pins show pixel p-1, and row/col show pixel p.
    task automatic check_outputs();
        int         n, q, qc, qr;
        logic [2:0] e_rgb;
        logic       e_hs, e_vs, e_fs;
        p     = k / D;
        n     = p % FRAME;
        e_rgb = 3'b000;
        e_hs  = 1'b1;
        e_vs  = 1'b1;
        e_fs  = 1'b0;
        if (p > 0) begin
            q  = (p - 1) % FRAME;
            qc = q % HT;
            qr = q / HT;
            if (qc < HV && qr < VV) e_rgb = samp;
            if (qc >= HV + HF && qc < HV + HF + HS) e_hs = 1'b0;
            if (qr >= VV + VF && qr < VV + VF + VS) e_vs = 1'b0;
            if (k % D == 0 && n == 0) e_fs = 1'b1;
        end
        chk("col",         32'(col),         32'(n % HT));
        chk("row",         32'(row),         32'(n / HT));
        chk("vga_rgb",     32'(vga_rgb),     32'(e_rgb));
        chk("vga_hsync",   32'(vga_hsync),   32'(e_hs));
        chk("vga_vsync",   32'(vga_vsync),   32'(e_vs));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
    endtask

    // Called at a falling edge: check the pins, drive the next inputs, then
    // advance one clock and the model with it.
    task automatic cycle(input logic rst_val);
        int mode;
        check_outputs();
        reset = rst_val;
        mode  = (p / FRAME) % 3;
        case (mode)
            0:       rgb = 3'($urandom_range(7, 0));
            1:       rgb = col[2:0];
            default: rgb = 3'b111;
        endcase
        @(posedge clk);
        if (rst_val) begin
            k    = 0;
            samp = 3'b000;
        end else begin
            k++;
            if (k % D == 0) samp = rgb;
        end
        @(negedge clk);
    endtask

    initial begin
        int guard;
        n_vec  = 0;
        n_miss = 0;
        k      = 0;
        p      = 0;
        samp   = 3'b000;
        reset  = 1'b1;
        rgb    = 3'b000;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);

        for (int i = 0; i < 3; i++) cycle(1'b1);
        for (int i = 0; i < 3 * FRAME_CLK + 50; i++) cycle(1'b0);

        // Run on to (col=13, row=7), with a random divider phase, then pulse reset.
        guard = 0;
        while (!((k / D) % FRAME == 7 * HT + 13) && guard < 2 * FRAME_CLK) begin
            cycle(1'b0);
            guard++;
        end
        for (int i = 0; i < int'($urandom_range(2, 0)); i++) cycle(1'b0);
        cycle(1'b1);

        for (int i = 0; i < 2 * FRAME_CLK + 100; i++) cycle(1'b0);
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
